serv_rf_ram_bridge: RTL

- Bridges the W-bit-per-cycle register-file ports of the bit-sliced core onto one single-port synchronous RAM of width RW.
- Serves two read ports (rs1, rs2/CSR) and two write ports (rd/mtval, CSR/mepc) per instruction.
- Prefetches, double-buffers and lane-masks RAM words so the core sees a plain W-bit stream.
- Sits between the register-file interface and the RF RAM macro, replacing direct wide-RF wiring.

---
 rtl/serv_rf_ram_bridge.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serv_rf_ram_bridge.sv
// serv_rf_ram_bridge: streams W-bit register-file beats to and from a single-port RW-wide RAM
module serv_rf_ram_bridge #(
   parameter int W = 8,
   parameter int RW = 32,
   parameter int WITH_CSR = 1,
   localparam int RATIO = RW / W,
   localparam int WPR = 32 / RW,
   localparam int RA = 5 + WITH_CSR,
   localparam int AW = $clog2((32 + 4 * WITH_CSR) * WPR)
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          i_rreq,
   output logic          o_ready,
   input  logic          i_cnt_en,
   input  logic [RA-1:0] i_rreg0,
   input  logic [RA-1:0] i_rreg1,
   input  logic [RA-1:0] i_wreg0,
   input  logic [RA-1:0] i_wreg1,
   input  logic          i_wen0,
   input  logic          i_wen1,
   input  logic [W-1:0]  i_wdata0,
   input  logic [W-1:0]  i_wdata1,
   output logic [W-1:0]  o_rdata0,
   output logic [W-1:0]  o_rdata1,
   output logic [AW-1:0] o_addr,
   output logic          o_ren,
   output logic          o_wen,
   output logic [RATIO-1:0] o_wmask,
   output logic [RW-1:0] o_wdata,
   input  logic [RW-1:0] i_ramrdata
);
   localparam int BW = $clog2(RATIO);
   localparam int LW = $clog2(WPR);
   localparam int KW = LW > 0 ? LW : 1;

   typedef enum logic [2:0] {IDLE, PRE0, PRE1, RUN, FLUSH0, FLUSH1} state_t;
   state_t state;

   logic [BW-1:0] b;
   logic [KW-1:0] k;
   logic [RW-1:0] cur0, cur1, nxt0, nxt1, wb0, wb1, hb0, hb1, wb0_n, wb1_n;
   logic [RATIO-1:0] wm0, wm1, hm0, hm1, wm0_n, wm1_n, mask;
   logic byp, cap0, cap1, pend, beat, wrap, more, last;

   function automatic logic [AW-1:0] ra(input logic [RA-1:0] r, input logic [KW-1:0] i);
      return (AW'(r) << LW) | AW'(i);
   endfunction

   assign beat = state == RUN && i_cnt_en;
   assign wrap = beat && b == BW'(RATIO - 1);
   assign more = k != KW'(WPR - 1);
   assign last = wrap && !more;
   assign o_rdata0 = cur0[b*W +: W];
   assign o_rdata1 = byp ? i_ramrdata[b*W +: W] : cur1[b*W +: W];

   // write buffers with the current beat's lane merged in
   always_comb begin
      wb0_n = wb0;
      wb1_n = wb1;
      wm0_n = wm0;
      wm1_n = wm1;
      wb0_n[b*W +: W] = i_wdata0;
      wb1_n[b*W +: W] = i_wdata1;
      wm0_n[b] = i_wen0;
      wm1_n[b] = i_wen1;
   end

   // RAM slot schedule: prefetch reads early in a word, write back the previous word later
   always_comb begin
      o_ren = 1'b0;
      o_addr = '0;
      o_wdata = hb0;
      mask = '0;
      case (state)
         PRE0: begin o_ren = 1'b1; o_addr = ra(i_rreg0, '0); end
         PRE1: begin o_ren = 1'b1; o_addr = ra(i_rreg1, '0); end
         RUN: if (i_cnt_en) begin
            if (b == BW'(0) && more) begin o_ren = 1'b1; o_addr = ra(i_rreg0, k + 1'b1); end
            else if (b == BW'(1) && more) begin o_ren = 1'b1; o_addr = ra(i_rreg1, k + 1'b1); end
            else if (b == BW'(2) && k != '0) begin o_addr = ra(i_wreg0, k - 1'b1); mask = hm0; end
            else if (b == BW'(3) && k != '0) begin o_addr = ra(i_wreg1, k - 1'b1); o_wdata = hb1; mask = hm1; end
         end
         FLUSH0: begin o_addr = ra(i_wreg0, KW'(WPR - 1)); mask = hm0; end
         FLUSH1: begin o_addr = ra(i_wreg1, KW'(WPR - 1)); o_wdata = hb1; mask = hm1; end
         default: ;
      endcase
      o_ren = o_ren && !i_rst;
      o_wen = |mask && !i_rst;
      o_wmask = o_wen ? mask : '0;
   end

   // control FSM: sequencing, beat/word counters, capture strobes and ready
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state <= IDLE;
         o_ready <= 1'b0;
         b <= '0;
         k <= '0;
         pend <= 1'b0;
         byp <= 1'b0;
         cap0 <= 1'b0;
         cap1 <= 1'b0;
      end else begin
         byp <= state == PRE1;
         cap0 <= beat && b == BW'(0) && more;
         cap1 <= beat && b == BW'(1) && more;
         if (beat) b <= b + 1'b1;
         if (wrap) k <= more ? k + 1'b1 : '0;
         case (state)
            IDLE: if (i_rreq) state <= PRE0;
            PRE0: state <= PRE1;
            PRE1: begin state <= RUN; o_ready <= 1'b1; end
            RUN: if (last) begin state <= FLUSH0; o_ready <= 1'b0; end
            FLUSH0: begin state <= FLUSH1; pend <= i_rreq; end
            FLUSH1: begin state <= (pend || i_rreq) ? PRE0 : IDLE; pend <= 1'b0; end
            default: state <= IDLE;
         endcase
      end
   end

   // datapath: read word capture, prefetch hand-over and write double-buffering
   always_ff @(posedge clk) begin
      if (state == PRE1) cur0 <= i_ramrdata;
      if (byp) cur1 <= i_ramrdata;
      if (cap0) nxt0 <= i_ramrdata;
      if (cap1) nxt1 <= i_ramrdata;
      if (beat) begin
         wb0 <= wb0_n;
         wb1 <= wb1_n;
         wm0 <= wm0_n;
         wm1 <= wm1_n;
      end
      if (wrap) begin
         cur0 <= nxt0;
         cur1 <= nxt1;
         hb0 <= wb0_n;
         hb1 <= wb1_n;
         hm0 <= wm0_n;
         hm1 <= wm1_n;
      end
   end
endmodule
